// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin one-shot timer arbiter.
package timer_arbiter_pkg;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, with wrap.
module rr_pick
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   last_owner,
    output logic [N-1:0]          winner,
    output logic                  valid
);

    localparam int unsigned LW = idx_w(N);

    logic [LW-1:0] sel;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sel    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            sel = LW'((32'(last_owner) + k) % N);
            if (!found && req[sel]) begin
                winner[sel] = 1'b1;
                found       = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/timer_arbiter.sv
// One-shot down-counter shared by N requesters, granted round-robin.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] delay,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy
);

    localparam int unsigned LW = idx_w(N);

    state_t        state;
    logic [W-1:0]  count;
    logic [LW-1:0] owner;
    logic [LW-1:0] last_owner;

    logic [N-1:0]  winner;
    logic          win_valid;
    logic [LW-1:0] win_idx;

    rr_pick #(.N(N)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (winner),
        .valid      (win_valid)
    );

    // One-hot winner to index.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner[i]) win_idx = LW'(i);
        end
    end

    // Abort takes priority over expiry so a dropped request never sees done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            count      <= '0;
            owner      <= '0;
            last_owner <= LW'(N - 1);
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state <= ST_COUNT;
                        grant <= winner;
                        count <= delay[32'(win_idx)*W +: W];
                        owner <= win_idx;
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (!req[owner]) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        count      <= '0;
                        last_owner <= owner;
                    end else if (count == '0) begin
                        state <= ST_DONE;
                        grant <= '0;
                        done  <= N'(1) << owner;
                    end else begin
                        count <= count - W'(1);
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    last_owner <= owner;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter (N=4, W=8).
module tb_timer_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;

    int unsigned n_cmp;
    int unsigned n_err;
    bit          mon_en;

    timer_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .delay   (delay),
        .grant   (grant),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ed,
                              input logic eb);
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".done"},  32'(done),  32'(ed));
        check({tag, ".busy"},  32'(busy),  32'(eb));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        delay   = '0;
        #1;
        check_outs("reset", '0, '0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Structural invariants sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("inv.grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("inv.done_onehot0",  32'($onehot0(done)),  32'd1);
            check("inv.done_and_grant", 32'(done & grant), 32'd0);
        end
    end

    initial begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        int unsigned  s;
        int unsigned  ph;

        n_cmp   = 0;
        n_err   = 0;
        mon_en  = 1'b0;
        req     = '0;
        delay   = '0;
        reset_n = 1'b0;
        #2;
        mon_en  = 1'b1;

        // Single request, D=5: grant cycles 1..6, done cycle 7, idle cycle 8.
        do_reset();
        req          = 4'b0001;
        delay[0*W +: W] = 8'd5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            eg = (c <= 6) ? 4'b0001 : 4'b0000;
            ed = (c == 7) ? 4'b0001 : 4'b0000;
            check_outs($sformatf("single.c%0d", c), eg, ed, (c <= 7) ? 1'b1 : 1'b0);
            if (c == 7) req = '0;
        end

        // Zero delay on index 2: grant cycle 1, done cycle 2.
        req          = 4'b0100;
        delay[2*W +: W] = 8'd0;
        tick();
        check_outs("zero.c1", 4'b0100, 4'b0000, 1'b1);
        tick();
        check_outs("zero.c2", 4'b0000, 4'b0100, 1'b1);
        req = '0;
        tick();
        check_outs("zero.c3", 4'b0000, 4'b0000, 1'b0);

        // Full contention, D=2: owners 0,1,2,3,0 on a 5-cycle period.
        do_reset();
        req   = 4'b1111;
        delay = {8'd2, 8'd2, 8'd2, 8'd2};
        for (int c = 1; c <= 21; c++) begin
            tick();
            s  = (c - 1) / 5;
            ph = (c - 1) % 5;
            eg = (ph <= 2) ? 4'(1 << (s % 4)) : 4'b0000;
            ed = (ph == 3) ? 4'(1 << (s % 4)) : 4'b0000;
            check_outs($sformatf("rr.c%0d", c), eg, ed, (ph <= 3) ? 1'b1 : 1'b0);
        end
        req = '0;
        tick();
        check_outs("rr.abort_idle", 4'b0000, 4'b0000, 1'b0);

        // Abort: owner 1 drops req in cycle 4; pending req[3] wins in cycle 6.
        req          = 4'b0010;
        delay[1*W +: W] = 8'd10;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4)      check_outs($sformatf("abort.c%0d", c), 4'b0010, 4'b0000, 1'b1);
            else if (c == 5) check_outs("abort.c5", 4'b0000, 4'b0000, 1'b0);
            else             check_outs("abort.c6", 4'b1000, 4'b0000, 1'b1);
            if (c == 2) begin
                delay[1*W +: W] = 8'd0;
                req             = 4'b0011;
            end
            if (c == 4) req = 4'b1001;
        end
        req = '0;
        tick();
        check_outs("abort.drop3", 4'b0000, 4'b0000, 1'b0);

        // Reset mid-count clears outputs asynchronously; index 0 wins after release.
        do_reset();
        req          = 4'b0001;
        delay[0*W +: W] = 8'd20;
        for (int c = 1; c <= 6; c++) tick();
        check_outs("rstmid.c6", 4'b0001, 4'b0000, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check_outs("rstmid.async", 4'b0000, 4'b0000, 1'b0);
        req   = 4'b1001;
        delay = {8'd1, 8'd0, 8'd0, 8'd1};
        tick();
        check_outs("rstmid.held", 4'b0000, 4'b0000, 1'b0);
        reset_n = 1'b1;
        tick();
        check_outs("rstmid.first", 4'b0001, 4'b0000, 1'b1);
        tick();
        check_outs("rstmid.cnt", 4'b0001, 4'b0000, 1'b1);
        tick();
        check_outs("rstmid.done", 4'b0000, 4'b0001, 1'b1);
        tick();
        check_outs("rstmid.gap", 4'b0000, 4'b0000, 1'b0);
        tick();
        check_outs("rstmid.next", 4'b1000, 4'b0000, 1'b1);
        req = '0;
        tick();
        tick();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
